debounce_bank: RTL and testbench

//   Parametrised multi-channel push-button debouncer for board switch/button inputs.
//   Per channel:
//   - synchronises the asynchronous pin;
//   - filters bounce with a stability counter;
//   - drives a clean level, 1-cycle press/release pulses and a 1-cycle long-press pulse.

---
 rtl/debounce_bank.sv | 87 ++++++++
 tb/tb_debounce_bank.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// Multi-channel push-button debouncer: synchroniser, stability-counter filter,
// registered level plus press/release/long-press pulses per channel.
module debounce_bank #(
  parameter int N_CH        = 4,
  parameter int DB_CYCLES   = 1000000,
  parameter int HOLD_CYCLES = 50000000,
  parameter int SYNC_STAGES = 2,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] btn_state,
  output logic [N_CH-1:0] btn_down,
  output logic [N_CH-1:0] btn_up,
  output logic [N_CH-1:0] btn_long
);

  localparam int DB_W   = $clog2(DB_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);

  logic [N_CH-1:0] sync_p [SYNC_STAGES];
  logic [N_CH-1:0] lvl;

  // Synchroniser stages
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
    end else begin
      sync_p[0] <= btn;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  assign lvl = (ACTIVE_LOW != 0) ? ~sync_p[SYNC_STAGES-1] : sync_p[SYNC_STAGES-1];

  // Debounce and hold qualification, one independent slice per channel
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              state_r;
    logic              down_r;
    logic              up_r;
    logic              long_r;

    always_ff @(posedge clk) begin
      if (rst) begin
        db_cnt   <= '0;
        hold_cnt <= '0;
        state_r  <= 1'b0;
        down_r   <= 1'b0;
        up_r     <= 1'b0;
        long_r   <= 1'b0;
      end else begin
        down_r <= 1'b0;
        up_r   <= 1'b0;
        // Any agreement with the accepted level restarts qualification
        if (lvl[g] == state_r) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          db_cnt  <= '0;
          state_r <= lvl[g];
          down_r  <= lvl[g];
          up_r    <= ~lvl[g];
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end

        if (!state_r) begin
          hold_cnt <= '0;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_cnt <= hold_cnt + 1'b1;
        end
        long_r <= state_r && (hold_cnt == HOLD_LAST);
      end
    end

    assign btn_state[g] = state_r;
    assign btn_down[g]  = down_r;
    assign btn_up[g]    = up_r;
    assign btn_long[g]  = long_r;
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: expected pulse events are queued by cycle when stimulus
// is driven, and compared against both an active-high and an active-low instance.
module tb_debounce_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn;
  logic [1:0] btn_n;
  logic [1:0] state_a, down_a, up_a, long_a;
  logic [1:0] state_b, down_b, up_b, long_b;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit chk_b;

  typedef struct {
    int         cyc;
    logic [5:0] val;
  } ev_t;
  ev_t evq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign btn_n = ~btn;

  debounce_bank #(.N_CH(2), .DB_CYCLES(4), .HOLD_CYCLES(10), .SYNC_STAGES(2), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst(rst), .btn(btn),
    .btn_state(state_a), .btn_down(down_a), .btn_up(up_a), .btn_long(long_a)
  );

  debounce_bank #(.N_CH(2), .DB_CYCLES(4), .HOLD_CYCLES(10), .SYNC_STAGES(2), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst(rst), .btn(btn_n),
    .btn_state(state_b), .btn_down(down_b), .btn_up(up_b), .btn_long(long_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Event layout: {long[1:0], up[1:0], down[1:0]}
  function automatic logic [5:0] ev_down(input logic [1:0] ch);
    return {4'b0000, ch};
  endfunction
  function automatic logic [5:0] ev_up(input logic [1:0] ch);
    return {2'b00, ch, 2'b00};
  endfunction
  function automatic logic [5:0] ev_long(input logic [1:0] ch);
    return {ch, 4'b0000};
  endfunction

  function automatic void expect_ev(input int at, input logic [5:0] v);
    ev_t e;
    e.cyc = at;
    e.val = v;
    for (int i = 0; i < evq.size(); i++) begin
      if (evq[i].cyc == at) begin
        evq[i].val = evq[i].val | v;
        return;
      end
      if (evq[i].cyc > at) begin
        evq.insert(i, e);
        return;
      end
    end
    evq.push_back(e);
  endfunction

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: every cycle, compare pulses against the queued expectation
  always @(negedge clk) begin
    logic [5:0] obs_a, obs_b;
    ev_t e;
    obs_a = {long_a, up_a, down_a};
    obs_b = {long_b, up_b, down_b};
    while (evq.size() > 0 && evq[0].cyc < cyc) begin
      e = evq.pop_front();
      check("missed_event", obs_a, e.val);
    end
    if (evq.size() > 0 && evq[0].cyc == cyc) begin
      e = evq.pop_front();
      check("pulse", obs_a, e.val);
      if (chk_b) check("pulse_al", obs_b, e.val);
    end else begin
      if (obs_a != 6'd0) check("spurious", obs_a, 6'd0);
      if (chk_b && obs_b != 6'd0) check("spurious_al", obs_b, 6'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: cycle %0d reached time limit, expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    int d;
    rst   = 1'b1;
    btn   = 2'b00;
    chk_b = 1'b1;

    // Reset
    goto(2);
    check("rst_state", state_a, 2'b00);
    check("rst_pulses", {long_a, up_a, down_a}, 6'd0);
    check("rst_state_al", state_b, 2'b00);
    goto(3);
    rst = 1'b0;

    // Press latency, long press and release
    goto(8);
    t = cyc;
    btn[0] = 1'b1;
    d = t + 6;
    expect_ev(d, ev_down(2'b01));
    expect_ev(d + 10, ev_long(2'b01));
    goto(d - 1);
    check("state_before", state_a, 2'b00);
    goto(d);
    check("state_press", state_a, 2'b01);
    check("state_press_al", state_b, 2'b01);
    goto(d + 1);
    check("down_clear", down_a, 2'b00);
    goto(d + 20);
    btn[0] = 1'b0;
    expect_ev(d + 26, ev_up(2'b01));
    goto(d + 27);
    check("state_release", state_a, 2'b00);

    // Bounce shorter than the qualification window
    goto(cyc + 2);
    t = cyc;
    btn[0] = 1'b1;
    goto(t + 3); btn[0] = 1'b0;
    goto(t + 4); btn[0] = 1'b1;
    goto(t + 7); btn[0] = 1'b0;
    goto(t + 20);
    check("bounce_state", state_a, 2'b00);

    // Short press: released before the long-press threshold
    t = cyc;
    btn[0] = 1'b1;
    d = t + 6;
    expect_ev(d, ev_down(2'b01));
    goto(d + 2);
    btn[0] = 1'b0;
    expect_ev(d + 8, ev_up(2'b01));
    goto(d + 20);
    check("short_state", state_a, 2'b00);

    // Both channels together; ch1 bounces while held
    t = cyc;
    btn = 2'b11;
    expect_ev(t + 6, ev_down(2'b11));
    expect_ev(t + 16, ev_long(2'b11));
    goto(t + 8);  btn[1] = 1'b0;
    goto(t + 10); btn[1] = 1'b1;
    goto(t + 14);
    check("both_state", state_a, 2'b11);
    goto(t + 20);
    btn = 2'b00;
    expect_ev(t + 26, ev_up(2'b11));
    goto(t + 30);
    check("both_released", state_a, 2'b00);

    // Reset while held: re-qualification from scratch
    chk_b = 1'b0;
    goto(cyc + 2);
    t = cyc;
    btn[0] = 1'b1;
    d = t + 6;
    expect_ev(d, ev_down(2'b01));
    goto(d + 2);
    rst = 1'b1;
    goto(d + 3);
    check("midrst_state", state_a, 2'b00);
    goto(d + 4);
    check("midrst_state2", state_a, 2'b00);
    rst = 1'b0;
    expect_ev(d + 10, ev_down(2'b01));
    expect_ev(d + 20, ev_long(2'b01));
    goto(d + 9);
    check("requal_pending", state_a, 2'b00);
    goto(d + 10);
    check("requal_state", state_a, 2'b01);
    goto(d + 22);
    btn[0] = 1'b0;
    expect_ev(d + 28, ev_up(2'b01));
    goto(d + 35);
    check("final_state", state_a, 2'b00);
    check("pending_events", evq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
